// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the CPU/PPU requesters, mem_arbiter and the memory controller.
// slave is the arbiter's view; master is the view of whatever drives the requests and the controller.
interface mem_arbiter_if;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 8;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic          read_a;
    logic          read_b;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_b;
    logic          busy;
    logic [1:0]    err;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  dout_a, dout_b, busy,
        output a_ack, a_rdata, b_ack, b_rdata,
        output read_a, read_b, write, addr, din, err
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output dout_a, dout_b, busy,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  read_a, read_b, write, addr, din, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU A / PPU B) arbiter in front of a single busy-handshaking memory controller.
// MEMARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise port B always wins a tie.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } slot_t;

    state_t state;
    slot_t  slot_a;
    slot_t  slot_b;
    slot_t  sel;
    logic   gnt_b;
    logic   done;
    logic   rel_a;
    logic   rel_b;
    logic   pick_b;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic   rr_b;
`endif

    // Slot release happens on the edge that completes the owning transaction.
    assign done  = (state == WAIT_DONE) && !bus.busy;
    assign rel_a = done && !gnt_b;
    assign rel_b = done &&  gnt_b;

    always_comb begin
        pick_b = 1'b0;
        if (slot_b.valid && !slot_a.valid) begin
            pick_b = 1'b1;
        end else if (slot_a.valid && slot_b.valid) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            pick_b = rr_b;
`else
            pick_b = 1'b1;
`endif
        end
        sel = pick_b ? slot_b : slot_a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot_a      <= '0;
            slot_b      <= '0;
            gnt_b       <= 1'b0;
            bus.a_ack   <= 1'b0;
            bus.b_ack   <= 1'b0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
            bus.read_a  <= 1'b0;
            bus.read_b  <= 1'b0;
            bus.write   <= 1'b0;
            bus.addr    <= '0;
            bus.din     <= '0;
            bus.err     <= 2'b00;
`ifdef MEMARB_ROUND_ROBIN_EN
            rr_b        <= 1'b0;
`endif
        end else begin
            bus.a_ack <= 1'b0;
            bus.b_ack <= 1'b0;

            // A request finding its slot occupied is dropped and flagged.
            if (bus.a_req) begin
                if (!slot_a.valid || rel_a)
                    slot_a <= '{valid: 1'b1, we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata};
                else
                    bus.err[0] <= 1'b1;
            end else if (rel_a) begin
                slot_a.valid <= 1'b0;
            end

            if (bus.b_req) begin
                if (!slot_b.valid || rel_b)
                    slot_b <= '{valid: 1'b1, we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata};
                else
                    bus.err[1] <= 1'b1;
            end else if (rel_b) begin
                slot_b.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Never issue while the controller still reports busy (e.g. after a reset abort).
                    if ((slot_a.valid || slot_b.valid) && !bus.busy) begin
                        gnt_b      <= pick_b;
                        bus.addr   <= sel.addr;
                        bus.din    <= sel.we ? sel.wdata : '0;
                        bus.write  <= sel.we;
                        bus.read_a <= !sel.we && !pick_b;
                        bus.read_b <= !sel.we &&  pick_b;
`ifdef MEMARB_ROUND_ROBIN_EN
                        rr_b       <= !pick_b;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.read_a <= 1'b0;
                    bus.read_b <= 1'b0;
                    bus.write  <= 1'b0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.busy) begin
                        if (gnt_b) begin
                            bus.b_ack <= 1'b1;
                            if (!slot_b.we)
                                bus.b_rdata <= bus.dout_b;
                        end else begin
                            bus.a_ack <= 1'b1;
                            if (!slot_a.we)
                                bus.a_rdata <= bus.dout_a;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
